// File: rtl/decoder_msg_packer.sv
// ---------------------------------------------------------------------------
// decoder_msg_packer
//
// Packs the serial message stream coming out of the constant-weight decoder
// into OUT_W-bit parallel words. The first received bit lands in the MSB.
// Words leave through a 2-entry FIFO on a valid/ready handshake.
//
// The decoder cannot be stalled, so:
//   - an ordinary full word that finds the FIFO full is dropped and the
//     sticky overflow flag is raised;
//   - the final word of a message is never dropped; it is parked in the
//     shift register and retried every cycle until the FIFO has room.
//
// Ports
//   clk        system clock, rising edge
//   rst_b      asynchronous active-low reset
//   start      one-cycle pulse, begins a new message (clears everything)
//   bin_msg    decoded message bit
//   msg_rdy    bin_msg is valid this cycle
//   msg_done   one-cycle pulse, message complete
//   out_word   packed word, MSB-aligned
//   out_valid  out_word / out_last / out_nbits are valid
//   out_ready  consumer accepts the word when high together with out_valid
//   out_last   this word is the final word of the message
//   out_nbits  number of valid bits in out_word
//   overflow   sticky, a full word was dropped because the FIFO was full
//   busy       high whenever the packer is not idle
// ---------------------------------------------------------------------------
module decoder_msg_packer #(
  parameter int OUT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             bin_msg,
  input  logic             msg_rdy,
  input  logic             msg_done,
  output logic [OUT_W-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] out_nbits,
  output logic             overflow,
  output logic             busy
);

  // One FIFO entry is {word, last, nbits}.
  localparam int ENT_W = OUT_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [OUT_W-1:0] sreg;
  logic [OUT_W-1:0] sreg_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Shift register / counter as they would look with this cycle's bit included.
  logic [OUT_W-1:0] bit_sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_full;
  logic [CNT_W-1:0] shamt;
  logic [OUT_W-1:0] final_word;

  logic [ENT_W-1:0] fifo_mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       fifo_cnt;
  logic [ENT_W-1:0] head;

  logic             pop;
  logic             can_push;
  logic             push_req;
  logic             push_en;
  logic [ENT_W-1:0] push_data;
  logic             ovf_set;

  // FIFO head drives the outputs; everything reads zero while the FIFO is
  // empty so nothing stale shows after a reset or a start.
  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_word  = out_valid ? head[ENT_W-1 -: OUT_W] : '0;
  assign out_last  = out_valid ? head[CNT_W] : 1'b0;
  assign out_nbits = out_valid ? head[CNT_W-1:0] : '0;
  assign busy      = (state != IDLE);

  // A push fits if the FIFO is not full, or if the head leaves this cycle.
  assign pop      = out_valid && out_ready;
  assign can_push = (fifo_cnt != 2'd2) || pop;
  assign push_en  = push_req && can_push;

  // Bit-level datapath: the shifted register and count with the current bit,
  // and the left-aligned version used for a final partial word. With zero
  // bits the shift is OUT_W, which yields the all-zero marker word.
  always_comb begin
    bit_sreg = sreg;
    bit_cnt  = cnt;
    if (msg_rdy) begin
      bit_sreg = {sreg[OUT_W-2:0], bin_msg};
      bit_cnt  = cnt + 1'b1;
    end
    word_full  = msg_rdy && (cnt == LAST_CNT);
    shamt      = FULL_CNT - bit_cnt;
    final_word = bit_sreg << shamt;
  end

  // Next-state logic. start overrides everything else in the same cycle.
  // While parked in FLUSH, sreg holds the final word and cnt its bit count.
  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    cnt_next   = cnt;
    push_req   = 1'b0;
    push_data  = '0;
    ovf_set    = 1'b0;

    case (state)
      IDLE: begin
      end

      COLLECT: begin
        sreg_next = bit_sreg;
        cnt_next  = bit_cnt;
        if (msg_done) begin
          push_req  = 1'b1;
          push_data = {final_word, 1'b1, bit_cnt};
          if (can_push) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            state_next = FLUSH;
            sreg_next  = final_word;
            cnt_next   = bit_cnt;
          end
        end else if (word_full) begin
          push_req  = 1'b1;
          push_data = {bit_sreg, 1'b0, FULL_CNT};
          cnt_next  = '0;
          if (!can_push) begin
            ovf_set = 1'b1;
          end
        end
      end

      FLUSH: begin
        push_req  = 1'b1;
        push_data = {sreg, 1'b1, cnt};
        if (can_push) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end
      end

      DRAIN: begin
        // Leave as soon as the last entry is being popped.
        if ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (start) begin
      state_next = COLLECT;
      sreg_next  = '0;
      cnt_next   = '0;
      push_req   = 1'b0;
      ovf_set    = 1'b0;
    end
  end

  // Control state, shift register, bit counter and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      sreg  <= sreg_next;
      cnt   <= cnt_next;
      if (start) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  // Two-entry FIFO. When full, a push and a pop in the same cycle write into
  // the slot that is being vacated, so nothing is lost.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else if (start) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push_en) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_msg_packer.sv
// ---------------------------------------------------------------------------
// tb_decoder_msg_packer
//
// Self-checking bench for decoder_msg_packer (OUT_W=8, CNT_W=4).
// A message-level model turns the driven bit stream into the expected word
// sequence and FIFO contents; a compare process checks the DUT against it
// every cycle. Each scenario also checks the accepted words against a
// hand-written list.
// ---------------------------------------------------------------------------
module tb_decoder_msg_packer;

  typedef struct packed {
    logic [7:0] word;
    logic       last;
    logic [3:0] nbits;
  } entry_t;

  typedef enum {M_IDLE, M_COLLECT, M_FLUSH, M_DRAIN} mode_t;

  logic       clk;
  logic       rst_b;
  logic       start;
  logic       bin_msg;
  logic       msg_rdy;
  logic       msg_done;
  logic [7:0] out_word;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] out_nbits;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model state
  bit     m_bits[$];
  entry_t m_fifo[$];
  entry_t m_pending;
  logic   m_ovf;
  mode_t  m_mode;

  // Words accepted by the consumer, and the hand-written expectation.
  entry_t act_log[$];
  entry_t exp_log[$];

  decoder_msg_packer #(
    .OUT_W(8),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .bin_msg   (bin_msg),
    .msg_rdy   (msg_rdy),
    .msg_done  (msg_done),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_nbits (out_nbits),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packs the collected bits MSB first; unused LSBs are zero.
  function automatic entry_t pack_bits(input bit q[$], input logic last);
    entry_t e;
    e.word = 8'h00;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i]) e.word[7-i] = 1'b1;
    end
    e.last  = last;
    e.nbits = 4'(q.size());
    return e;
  endfunction

  // Message-level model, advanced on every rising edge.
  always @(posedge clk) begin
    bit     room;
    entry_t e;
    if (!rst_b) begin
      m_bits.delete();
      m_fifo.delete();
      m_ovf  = 1'b0;
      m_mode = M_IDLE;
    end else if (start) begin
      m_bits.delete();
      m_fifo.delete();
      m_ovf  = 1'b0;
      m_mode = M_COLLECT;
    end else begin
      if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
      room = (m_fifo.size() < 2);
      case (m_mode)
        M_COLLECT: begin
          if (msg_rdy) m_bits.push_back(bin_msg);
          if (msg_done) begin
            e = pack_bits(m_bits, 1'b1);
            m_bits.delete();
            if (room) begin
              m_fifo.push_back(e);
              m_mode = M_DRAIN;
            end else begin
              m_pending = e;
              m_mode    = M_FLUSH;
            end
          end else if (m_bits.size() == 8) begin
            e = pack_bits(m_bits, 1'b0);
            m_bits.delete();
            if (room) m_fifo.push_back(e);
            else m_ovf = 1'b1;
          end
        end
        M_FLUSH: begin
          if (room) begin
            m_fifo.push_back(m_pending);
            m_mode = M_DRAIN;
          end
        end
        M_DRAIN: begin
          if (m_fifo.size() == 0) m_mode = M_IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_b) begin
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_out_word", 32'(out_word), 32'd0);
      check_output("rst_out_last", 32'(out_last), 32'd0);
      check_output("rst_out_nbits", 32'(out_nbits), 32'd0);
      check_output("rst_overflow", 32'(overflow), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
    end else begin
      check_output("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
        check_output("out_word", 32'(out_word), 32'(m_fifo[0].word));
        check_output("out_last", 32'(out_last), 32'(m_fifo[0].last));
        check_output("out_nbits", 32'(out_nbits), 32'(m_fifo[0].nbits));
      end
      check_output("overflow", 32'(overflow), 32'(m_ovf));
      check_output("busy", 32'(busy), 32'(m_mode != M_IDLE));
      if (out_valid && out_ready) begin
        act_log.push_back('{word: out_word, last: out_last, nbits: out_nbits});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends the low n bits of val, MSB first. Optional idle gap after each bit
  // (with a garbage bin_msg) and msg_done on the last bit.
  task automatic apply_stimulus(input logic [31:0] val, input int n,
                                input bit gap, input bit done_last);
    for (int i = n - 1; i >= 0; i--) begin
      bin_msg  = val[i];
      msg_rdy  = 1'b1;
      msg_done = done_last && (i == 0);
      tick();
      if (gap) begin
        bin_msg  = ~val[i];
        msg_rdy  = 1'b0;
        msg_done = 1'b0;
        tick();
      end
    end
    bin_msg  = 1'b0;
    msg_rdy  = 1'b0;
    msg_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check_output("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_log(input string name);
    check_output({name, "_count"}, 32'(act_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < act_log.size(); i++) begin
      check_output($sformatf("%s_word%0d", name, i), 32'(act_log[i]), 32'(exp_log[i]));
    end
    act_log.delete();
    exp_log.delete();
  endtask

  initial begin
    rst_b     = 1'b0;
    start     = 1'b0;
    bin_msg   = 1'b0;
    msg_rdy   = 1'b0;
    msg_done  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_valid", 32'(out_valid), 32'd0);
    rst_b = 1'b1;
    tick();

    // Two full words, msg_done on bit 16: no marker word.
    $display("[TB] two full words");
    act_log.delete();
    pulse_start();
    apply_stimulus(32'h52, 7, 1'b0, 1'b0);
    check_output("lat_before_bit8", 32'(out_valid), 32'd0);
    apply_stimulus(32'h1, 1, 1'b0, 1'b0);
    check_output("lat_after_bit8", 32'(out_valid), 32'd1);
    check_output("lat_word", 32'(out_word), 32'hA5);
    apply_stimulus(32'h3C, 8, 1'b0, 1'b1);
    wait_idle();
    exp_log.push_back('{word: 8'hA5, last: 1'b0, nbits: 4'd8});
    exp_log.push_back('{word: 8'h3C, last: 1'b1, nbits: 4'd8});
    check_log("full_words");

    // 11 bits, msg_done a cycle after the last bit.
    $display("[TB] partial final word");
    pulse_start();
    apply_stimulus(32'h59D, 11, 1'b0, 1'b0);
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    wait_idle();
    exp_log.push_back('{word: 8'hB3, last: 1'b0, nbits: 4'd8});
    exp_log.push_back('{word: 8'hA0, last: 1'b1, nbits: 4'd3});
    check_log("partial");

    // Empty message: marker word only.
    $display("[TB] empty message");
    pulse_start();
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    wait_idle();
    check_output("empty_busy", 32'(busy), 32'd0);
    exp_log.push_back('{word: 8'h00, last: 1'b1, nbits: 4'd0});
    check_log("empty");

    // Consumer stalled for a 32-bit message: words 3 is dropped, word 4 waits.
    $display("[TB] back-pressure");
    out_ready = 1'b0;
    pulse_start();
    apply_stimulus(32'h89119, 23, 1'b0, 1'b0);
    check_output("ovf_before_w3", 32'(overflow), 32'd0);
    apply_stimulus(32'h1, 1, 1'b0, 1'b0);
    check_output("ovf_after_w3", 32'(overflow), 32'd1);
    apply_stimulus(32'h44, 8, 1'b0, 1'b1);
    tick();
    tick();
    check_output("stall_busy", 32'(busy), 32'd1);
    check_output("stall_head", 32'(out_word), 32'h11);
    out_ready = 1'b1;
    wait_idle();
    check_output("ovf_sticky", 32'(overflow), 32'd1);
    exp_log.push_back('{word: 8'h11, last: 1'b0, nbits: 4'd8});
    exp_log.push_back('{word: 8'h22, last: 1'b0, nbits: 4'd8});
    exp_log.push_back('{word: 8'h44, last: 1'b1, nbits: 4'd8});
    check_log("backpressure");

    // msg_rdy gaps; start also clears the sticky overflow.
    $display("[TB] gaps");
    pulse_start();
    check_output("start_clears_ovf", 32'(overflow), 32'd0);
    apply_stimulus(32'hF0, 8, 1'b1, 1'b1);
    wait_idle();
    exp_log.push_back('{word: 8'hF0, last: 1'b1, nbits: 4'd8});
    check_log("gaps");

    // Reset in the middle of a message.
    $display("[TB] reset mid-message");
    pulse_start();
    apply_stimulus(32'h1F, 5, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    check_output("midrst_valid", 32'(out_valid), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    pulse_start();
    apply_stimulus(32'h5A, 8, 1'b0, 1'b1);
    wait_idle();
    exp_log.push_back('{word: 8'h5A, last: 1'b1, nbits: 4'd8});
    check_log("after_reset");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
